// File: rtl/huffman_param.sv
// huffman_param: histograms a stream of symbols (1..NSYM), builds a Huffman
// tree one merge per cycle, then walks every leaf toward the root in parallel
// (one level per cycle) to produce right-aligned codes and length masks.
//
// Parameters: NSYM (2..15), SYM_W, CNT_W, CODE_W (>= 1).
// Ports:
//   clk, reset (async, active-high)
//   gray_valid / gray_data : symbol strobe and value
//   busy                   : high in MERGE/CODE/DONE, strobes ignored
//   cnt_valid / cnt_flat   : one-cycle pulse with final histogram
//   code_valid / code_err  : one-cycle pulse with codes, overflow flag
//   hc_flat / m_flat       : per-slot codes and length masks
// Build option: HUFF_CNT_SAT_EN defined -> histogram counters saturate,
// otherwise they wrap modulo 2^CNT_W.
module huffman_param #(
  parameter int unsigned NSYM   = 6,
  parameter int unsigned SYM_W  = 8,
  parameter int unsigned CNT_W  = 8,
  parameter int unsigned CODE_W = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   gray_valid,
  input  logic [SYM_W-1:0]       gray_data,
  output logic                   busy,
  output logic                   cnt_valid,
  output logic [NSYM*CNT_W-1:0]  cnt_flat,
  output logic                   code_valid,
  output logic                   code_err,
  output logic [NSYM*CODE_W-1:0] hc_flat,
  output logic [NSYM*CODE_W-1:0] m_flat
);

  localparam int unsigned NN  = 2 * NSYM - 1;
  localparam int unsigned IW  = $clog2(NN);
  localparam int unsigned NCW = CNT_W + 4;
  localparam int unsigned LW  = $clog2(CODE_W + 1);
  localparam int unsigned KW  = $clog2(NSYM + 1);

  typedef enum logic [2:0] {S_IDLE, S_COUNT, S_MERGE, S_CODE, S_DONE} state_e;

  state_e                  state_q;
  logic [CNT_W-1:0]        cnt_q   [NSYM];
  logic [NCW-1:0]          ncnt_q  [NN];
  logic                    act_q   [NN];
  logic [IW-1:0]           par_q   [NN];
  logic                    pv_q    [NN];
  logic                    edg_q   [NN];
  logic [IW-1:0]           nxt_q;
  logic [KW-1:0]           rem_q;
  logic [IW-1:0]           cur_q   [NSYM];
  logic [LW-1:0]           len_q   [NSYM];
  logic                    fin_q   [NSYM];
  logic [CODE_W-1:0]       hcw_q   [NSYM];
  logic [CODE_W-1:0]       mw_q    [NSYM];
  logic                    err_q;

  logic                    busy_q, cnt_valid_q, code_valid_q, code_err_q;
  logic [NSYM*CNT_W-1:0]   cnt_flat_q;
  logic [NSYM*CODE_W-1:0]  hc_flat_q, m_flat_q;

  logic [NSYM-1:0]         sym_hit_c;
  logic                    any_hit_c;
  logic [CNT_W-1:0]        cnt_inc_c [NSYM];
  logic [KW-1:0]           k_c;
  logic [IW-1:0]           min1_c, min2_c;
  logic [NCW-1:0]          v1_c, v2_c, sum_c;
  logic                    f1_c, f2_c;
  logic [IW-1:0]           cur_d   [NSYM];
  logic [LW-1:0]           len_d   [NSYM];
  logic                    fin_d   [NSYM];
  logic [CODE_W-1:0]       hcw_d   [NSYM];
  logic [CODE_W-1:0]       mw_d    [NSYM];
  logic [CODE_W-1:0]       oh_c    [NSYM];
  logic                    walk_err_c, all_fin_c;

  assign busy       = busy_q;
  assign cnt_valid  = cnt_valid_q;
  assign cnt_flat   = cnt_flat_q;
  assign code_valid = code_valid_q;
  assign code_err   = code_err_q;
  assign hc_flat    = hc_flat_q;
  assign m_flat     = m_flat_q;

  // Symbol decode, counter increment and count of nonzero slots.
  always_comb begin
    sym_hit_c = '0;
    k_c       = '0;
    for (int i = 0; i < NSYM; i++) begin
      sym_hit_c[i] = gray_valid && (gray_data == SYM_W'(i + 1));
`ifdef HUFF_CNT_SAT_EN
      cnt_inc_c[i] = (cnt_q[i] == '1) ? cnt_q[i] : cnt_q[i] + CNT_W'(1);
`else
      cnt_inc_c[i] = cnt_q[i] + CNT_W'(1);
`endif
      k_c = k_c + KW'(cnt_q[i] != '0);
    end
    any_hit_c = |sym_hit_c;
  end

  // Two smallest active nodes; ascending scan with strict compare keeps the
  // lower index on ties.
  always_comb begin
    min1_c = '0;
    min2_c = '0;
    v1_c   = '0;
    v2_c   = '0;
    f1_c   = 1'b0;
    f2_c   = 1'b0;
    for (int n = 0; n < NN; n++) begin
      if (act_q[n] && (!f1_c || ncnt_q[n] < v1_c)) begin
        min1_c = IW'(n);
        v1_c   = ncnt_q[n];
        f1_c   = 1'b1;
      end
    end
    for (int n = 0; n < NN; n++) begin
      if (act_q[n] && (IW'(n) != min1_c) && (!f2_c || ncnt_q[n] < v2_c)) begin
        min2_c = IW'(n);
        v2_c   = ncnt_q[n];
        f2_c   = 1'b1;
      end
    end
    sum_c = v1_c + v2_c;
  end

  // One CODE step for every unfinished leaf.
  always_comb begin
    walk_err_c = 1'b0;
    all_fin_c  = 1'b1;
    for (int i = 0; i < NSYM; i++) begin
      cur_d[i] = cur_q[i];
      len_d[i] = len_q[i];
      fin_d[i] = fin_q[i];
      hcw_d[i] = hcw_q[i];
      mw_d[i]  = mw_q[i];
      oh_c[i]  = CODE_W'(1) << len_q[i];
      if (!fin_q[i]) begin
        if (len_q[i] == LW'(CODE_W)) begin
          // Code would exceed CODE_W bits: flag and blank the slot.
          walk_err_c = 1'b1;
          hcw_d[i]   = '0;
          mw_d[i]    = '0;
          fin_d[i]   = 1'b1;
        end else if (!pv_q[cur_q[i]]) begin
          // Lone active leaf is itself the root: 1-bit code 0.
          mw_d[i]  = oh_c[i];
          fin_d[i] = 1'b1;
        end else begin
          if (edg_q[cur_q[i]]) hcw_d[i] = hcw_q[i] | oh_c[i];
          mw_d[i]  = mw_q[i] | oh_c[i];
          len_d[i] = len_q[i] + LW'(1);
          cur_d[i] = par_q[cur_q[i]];
          fin_d[i] = !pv_q[par_q[cur_q[i]]];
        end
      end
      all_fin_c = all_fin_c & fin_d[i];
    end
  end

  // Control FSM with histogram, tree and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      nxt_q        <= '0;
      rem_q        <= '0;
      err_q        <= 1'b0;
      busy_q       <= 1'b0;
      cnt_valid_q  <= 1'b0;
      code_valid_q <= 1'b0;
      code_err_q   <= 1'b0;
      cnt_flat_q   <= '0;
      hc_flat_q    <= '0;
      m_flat_q     <= '0;
      for (int n = 0; n < NN; n++) begin
        ncnt_q[n] <= '0;
        act_q[n]  <= 1'b0;
        par_q[n]  <= '0;
        pv_q[n]   <= 1'b0;
        edg_q[n]  <= 1'b0;
      end
      for (int i = 0; i < NSYM; i++) begin
        cnt_q[i] <= '0;
        cur_q[i] <= '0;
        len_q[i] <= '0;
        fin_q[i] <= 1'b0;
        hcw_q[i] <= '0;
        mw_q[i]  <= '0;
      end
    end else begin
      cnt_valid_q  <= 1'b0;
      code_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          for (int i = 0; i < NSYM; i++)
            if (sym_hit_c[i]) cnt_q[i] <= cnt_inc_c[i];
          if (any_hit_c) state_q <= S_COUNT;
        end
        S_COUNT: begin
          if (gray_valid) begin
            for (int i = 0; i < NSYM; i++)
              if (sym_hit_c[i]) cnt_q[i] <= cnt_inc_c[i];
          end else begin
            // End of block: publish counts and seed the tree with the leaves.
            cnt_valid_q <= 1'b1;
            busy_q      <= 1'b1;
            err_q       <= 1'b0;
            nxt_q       <= IW'(NSYM);
            rem_q       <= k_c - KW'(1);
            state_q     <= (k_c > KW'(1)) ? S_MERGE : S_CODE;
            for (int n = 0; n < NN; n++) begin
              ncnt_q[n] <= '0;
              act_q[n]  <= 1'b0;
              par_q[n]  <= '0;
              pv_q[n]   <= 1'b0;
              edg_q[n]  <= 1'b0;
            end
            for (int i = 0; i < NSYM; i++) begin
              cnt_flat_q[i*CNT_W +: CNT_W] <= cnt_q[i];
              ncnt_q[i] <= NCW'(cnt_q[i]);
              act_q[i]  <= (cnt_q[i] != '0);
              cur_q[i]  <= IW'(i);
              len_q[i]  <= '0;
              fin_q[i]  <= (cnt_q[i] == '0);
              hcw_q[i]  <= '0;
              mw_q[i]   <= '0;
            end
          end
        end
        S_MERGE: begin
          ncnt_q[nxt_q] <= sum_c;
          act_q[nxt_q]  <= 1'b1;
          act_q[min1_c] <= 1'b0;
          act_q[min2_c] <= 1'b0;
          par_q[min1_c] <= nxt_q;
          par_q[min2_c] <= nxt_q;
          pv_q[min1_c]  <= 1'b1;
          pv_q[min2_c]  <= 1'b1;
          edg_q[min1_c] <= 1'b1;
          edg_q[min2_c] <= 1'b0;
          nxt_q         <= nxt_q + IW'(1);
          rem_q         <= rem_q - KW'(1);
          if (rem_q == KW'(1)) state_q <= S_CODE;
        end
        S_CODE: begin
          for (int i = 0; i < NSYM; i++) begin
            cur_q[i] <= cur_d[i];
            len_q[i] <= len_d[i];
            fin_q[i] <= fin_d[i];
            hcw_q[i] <= hcw_d[i];
            mw_q[i]  <= mw_d[i];
          end
          if (walk_err_c) err_q <= 1'b1;
          if (all_fin_c) begin
            state_q      <= S_DONE;
            code_valid_q <= 1'b1;
            code_err_q   <= err_q | walk_err_c;
            for (int i = 0; i < NSYM; i++) begin
              hc_flat_q[i*CODE_W +: CODE_W] <= hcw_d[i];
              m_flat_q[i*CODE_W +: CODE_W]  <= mw_d[i];
            end
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
          for (int i = 0; i < NSYM; i++) cnt_q[i] <= '0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_huffman_param.sv
// Self-checking bench for huffman_param: directed scenarios plus randomized
// blocks compared against a procedural Huffman reference model.
module tb_huffman_param;

  localparam int unsigned NSYM    = 6;
  localparam int unsigned SYM_W   = 8;
  localparam int unsigned CNT_W   = 8;
  localparam int unsigned CODE_W  = 8;
  localparam int unsigned NSYM2   = 4;
  localparam int unsigned CODE_W2 = 2;
  localparam int          CMAX    = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic reset;
  logic gray_valid;
  logic [SYM_W-1:0] gray_data;
  logic busy, cnt_valid, code_valid, code_err;
  logic [NSYM*CNT_W-1:0]  cnt_flat;
  logic [NSYM*CODE_W-1:0] hc_flat, m_flat;

  logic g2_valid;
  logic [SYM_W-1:0] g2_data;
  logic busy2, cnt_valid2, code_valid2, code_err2;
  logic [NSYM2*CNT_W-1:0]   cnt_flat2;
  logic [NSYM2*CODE_W2-1:0] hc2, m2;

  always #5 clk = ~clk;

  huffman_param #(.NSYM(NSYM), .SYM_W(SYM_W), .CNT_W(CNT_W), .CODE_W(CODE_W)) u_dut (
    .clk(clk), .reset(reset), .gray_valid(gray_valid), .gray_data(gray_data),
    .busy(busy), .cnt_valid(cnt_valid), .cnt_flat(cnt_flat),
    .code_valid(code_valid), .code_err(code_err), .hc_flat(hc_flat), .m_flat(m_flat));

  huffman_param #(.NSYM(NSYM2), .SYM_W(SYM_W), .CNT_W(CNT_W), .CODE_W(CODE_W2)) u_dut2 (
    .clk(clk), .reset(reset), .gray_valid(g2_valid), .gray_data(g2_data),
    .busy(busy2), .cnt_valid(cnt_valid2), .cnt_flat(cnt_flat2),
    .code_valid(code_valid2), .code_err(code_err2), .hc_flat(hc2), .m_flat(m2));

  int checks = 0;
  int errors = 0;

  // Reference model state
  int mdl_cnt [16];
  int mdl_hc  [16];
  int mdl_m   [16];
  bit mdl_err;
  int mdl_lat;

  // Observations captured by run_block
  int obs_lat;
  logic obs_cv, obs_busy_e1, obs_busy_ok, obs_busy_after, obs_err;
  logic [NSYM*CNT_W-1:0]  obs_cnt;
  logic [NSYM*CODE_W-1:0] obs_hc, obs_m;

  task automatic hist(input int q[$], input int ns);
    for (int i = 0; i < 16; i++) mdl_cnt[i] = 0;
    foreach (q[j]) begin
      if (q[j] >= 1 && q[j] <= ns) begin
`ifdef HUFF_CNT_SAT_EN
        if (mdl_cnt[q[j]-1] < CMAX) mdl_cnt[q[j]-1]++;
`else
        mdl_cnt[q[j]-1] = (mdl_cnt[q[j]-1] + 1) % (CMAX + 1);
`endif
      end
    end
  endtask

  // Classic Huffman build over weight/parent arrays, then walk leaf->root.
  task automatic ref_model(input int ns, input int cw);
    int w [32]; int par [32]; int eb [32]; bit alive [32];
    int nodes, k, depth, a, b, len, code, nd;
    nodes = ns; k = 0; depth = 0; mdl_err = 0;
    for (int i = 0; i < 32; i++) begin w[i] = 0; par[i] = -1; eb[i] = 0; alive[i] = 0; end
    for (int i = 0; i < ns; i++) begin
      w[i] = mdl_cnt[i]; alive[i] = (mdl_cnt[i] != 0);
      if (mdl_cnt[i] != 0) k++;
    end
    for (int r = 0; r < k - 1; r++) begin
      a = -1; b = -1;
      for (int i = 0; i < nodes; i++) begin
        if (alive[i]) begin
          if (a < 0 || w[i] < w[a]) begin b = a; a = i; end
          else if (b < 0 || w[i] < w[b]) b = i;
        end
      end
      w[nodes] = w[a] + w[b]; alive[nodes] = 1; alive[a] = 0; alive[b] = 0;
      par[a] = nodes; par[b] = nodes; eb[a] = 1; eb[b] = 0;
      nodes++;
    end
    for (int i = 0; i < 16; i++) begin mdl_hc[i] = 0; mdl_m[i] = 0; end
    for (int i = 0; i < ns; i++) begin
      if (mdl_cnt[i] != 0) begin
        len = 0; code = 0; nd = i;
        while (par[nd] >= 0) begin code = code | (eb[nd] << len); len++; nd = par[nd]; end
        if (k == 1) len = 1;
        if (len > depth) depth = len;
        if (len > cw) mdl_err = 1;
        else begin mdl_hc[i] = code; mdl_m[i] = (1 << len) - 1; end
      end
    end
    mdl_lat = k + depth;
  endtask

  function automatic logic [NSYM*CNT_W-1:0] exp_cnt_vec();
    logic [NSYM*CNT_W-1:0] v;
    v = '0;
    for (int i = 0; i < NSYM; i++) v[i*CNT_W +: CNT_W] = CNT_W'(mdl_cnt[i]);
    return v;
  endfunction

  function automatic logic [NSYM*CODE_W-1:0] exp_hc_vec();
    logic [NSYM*CODE_W-1:0] v;
    v = '0;
    for (int i = 0; i < NSYM; i++) v[i*CODE_W +: CODE_W] = CODE_W'(mdl_hc[i]);
    return v;
  endfunction

  function automatic logic [NSYM*CODE_W-1:0] exp_m_vec();
    logic [NSYM*CODE_W-1:0] v;
    v = '0;
    for (int i = 0; i < NSYM; i++) v[i*CODE_W +: CODE_W] = CODE_W'(mdl_m[i]);
    return v;
  endfunction

  // Drives one block into u_dut and records what happens from E+1 on.
  // junk > 0 raises gray_valid during the first busy cycles.
  task automatic run_block(input int q[$], input int junk);
    foreach (q[j]) begin
      @(negedge clk);
      gray_valid = 1'b1;
      gray_data  = SYM_W'(q[j]);
    end
    @(negedge clk);
    gray_valid = 1'b0;
    gray_data  = '0;
    @(posedge clk); #1;
    obs_cv = cnt_valid; obs_cnt = cnt_flat; obs_busy_e1 = busy;
    obs_lat = -1; obs_busy_ok = 1'b1; obs_err = 1'b0; obs_hc = '0; obs_m = '0;
    for (int n = 1; n <= 200 && obs_lat < 0; n++) begin
      if (n > 1) begin @(posedge clk); #1; end
      if (busy !== 1'b1) obs_busy_ok = 1'b0;
      if (code_valid === 1'b1) begin
        obs_lat = n; obs_hc = hc_flat; obs_m = m_flat; obs_err = code_err;
        gray_valid = 1'b0;
      end else begin
        gray_valid = (n <= junk);
        gray_data  = SYM_W'(1);
      end
    end
    gray_valid = 1'b0;
    @(posedge clk); #1;
    obs_busy_after = busy;
  endtask

  task automatic test_reset;
    reset = 1'b1; gray_valid = 1'b0; gray_data = '0; g2_valid = 1'b0; g2_data = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({busy, cnt_valid, code_valid, code_err, cnt_flat, hc_flat, m_flat} !== '0) begin
      errors++; $display("FAIL reset_outputs: got busy=%b cv=%b kv=%b cnt=%h hc=%h m=%h, want all 0",
                         busy, cnt_valid, code_valid, cnt_flat, hc_flat, m_flat);
    end
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({busy, busy2, cnt_valid, code_valid} !== 4'b0) begin
      errors++; $display("FAIL reset_idle: got busy=%b busy2=%b cv=%b kv=%b, want 0", busy, busy2, cnt_valid, code_valid);
    end
  endtask

  task automatic test_spec_vector;
    int q[$];
    q = {};
    for (int s = 1; s <= 6; s++) for (int r = 0; r < s; r++) q.push_back(s);
    run_block(q, 0);
    checks++;
    if (obs_cv !== 1'b1 || obs_busy_e1 !== 1'b1) begin
      errors++; $display("FAIL spec_e1: cnt_valid=%b busy=%b at E+1, want 1 1", obs_cv, obs_busy_e1);
    end
    checks++;
    if (obs_cnt !== 48'h060504030201) begin
      errors++; $display("FAIL spec_cnt: got %h want 060504030201", obs_cnt);
    end
    checks++;
    if (obs_lat !== 10) begin
      errors++; $display("FAIL spec_latency: got E+%0d want E+10", obs_lat);
    end
    checks++;
    if (obs_hc !== 48'h010203010001) begin
      errors++; $display("FAIL spec_hc: got %h want 010203010001", obs_hc);
    end
    checks++;
    if (obs_m !== 48'h030303070f0f) begin
      errors++; $display("FAIL spec_m: got %h want 030303070f0f", obs_m);
    end
    checks++;
    if (obs_err !== 1'b0 || obs_busy_ok !== 1'b1 || obs_busy_after !== 1'b0) begin
      errors++; $display("FAIL spec_flags: err=%b busy_ok=%b busy_after=%b want 0 1 0", obs_err, obs_busy_ok, obs_busy_after);
    end
  endtask

  task automatic test_single;
    int q[$];
    q = {3, 3, 3, 3, 3};
    run_block(q, 0);
    checks++;
    if (obs_cnt !== 48'h000000050000) begin
      errors++; $display("FAIL single_cnt: got %h want 000000050000", obs_cnt);
    end
    checks++;
    if (obs_hc !== '0 || obs_m !== 48'h000000010000) begin
      errors++; $display("FAIL single_code: got hc=%h m=%h want hc=0 m=000000010000", obs_hc, obs_m);
    end
    checks++;
    if (obs_lat !== 2) begin
      errors++; $display("FAIL single_latency: got E+%0d want E+2", obs_lat);
    end
  endtask

  task automatic test_invalid;
    int q[$];
    q = {0, 1, 7, 255, 2, 0, 1, 255, 7, 2};
    run_block(q, 0);
    checks++;
    if (obs_cnt !== 48'h000000000202) begin
      errors++; $display("FAIL invalid_cnt: got %h want 000000000202", obs_cnt);
    end
    checks++;
    if (obs_hc !== 48'h000000000001 || obs_m !== 48'h000000000101) begin
      errors++; $display("FAIL invalid_code: got hc=%h m=%h want hc=01 m=0101", obs_hc, obs_m);
    end
    checks++;
    if (obs_lat !== 3) begin
      errors++; $display("FAIL invalid_latency: got E+%0d want E+3", obs_lat);
    end
  endtask

  task automatic test_counter_limit;
    int q[$];
    int exp1;
    q = {};
    for (int j = 0; j < 300; j++) q.push_back(1);
    q.push_back(2);
    hist(q, NSYM);
    ref_model(NSYM, CODE_W);
`ifdef HUFF_CNT_SAT_EN
    exp1 = 255;
`else
    exp1 = 44;
`endif
    run_block(q, 0);
    checks++;
    if (obs_cnt[CNT_W-1:0] !== CNT_W'(exp1) || obs_cnt[2*CNT_W-1:CNT_W] !== CNT_W'(1)) begin
      errors++; $display("FAIL limit_cnt: got %h want slot0=%0d slot1=1", obs_cnt, exp1);
    end
    checks++;
    if (obs_hc !== exp_hc_vec() || obs_m !== exp_m_vec()) begin
      errors++; $display("FAIL limit_code: got hc=%h m=%h want hc=%h m=%h", obs_hc, obs_m, exp_hc_vec(), exp_m_vec());
    end
  endtask

  task automatic test_code_err;
    int q[$];
    int lat;
    logic got_err;
    logic [NSYM2*CODE_W2-1:0] got_hc, got_m;
    q = {1, 2, 2, 3, 3, 3, 3, 4, 4, 4, 4, 4, 4, 4, 4};
    hist(q, NSYM2);
    ref_model(NSYM2, CODE_W2);
    foreach (q[j]) begin
      @(negedge clk); g2_valid = 1'b1; g2_data = SYM_W'(q[j]);
    end
    @(negedge clk); g2_valid = 1'b0; g2_data = '0;
    @(posedge clk); #1;
    checks++;
    if (cnt_valid2 !== 1'b1 || cnt_flat2 !== 32'h08040201) begin
      errors++; $display("FAIL err_cnt: cv=%b cnt=%h want 1 08040201", cnt_valid2, cnt_flat2);
    end
    lat = -1; got_err = 1'b0; got_hc = '0; got_m = '0;
    for (int n = 1; n <= 200 && lat < 0; n++) begin
      if (n > 1) begin @(posedge clk); #1; end
      if (code_valid2 === 1'b1) begin lat = n; got_err = code_err2; got_hc = hc2; got_m = m2; end
    end
    checks++;
    if (lat < 0 || got_err !== 1'b1 || mdl_err !== 1'b1) begin
      errors++; $display("FAIL err_flag: lat=%0d code_err=%b model_err=%b want valid and 1", lat, got_err, mdl_err);
    end
    checks++;
    if (got_hc !== 8'h20 || got_m !== 8'h70) begin
      errors++; $display("FAIL err_codes: got hc=%h m=%h want hc=20 m=70", got_hc, got_m);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_merge;
    int q[$];
    logic seen;
    q = {};
    for (int s = 1; s <= 6; s++) for (int r = 0; r < s; r++) q.push_back(s);
    foreach (q[j]) begin
      @(negedge clk); gray_valid = 1'b1; gray_data = SYM_W'(q[j]);
    end
    @(negedge clk); gray_valid = 1'b0; gray_data = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    checks++;
    if ({busy, cnt_valid, code_valid, code_err, cnt_flat, hc_flat, m_flat} !== '0) begin
      errors++; $display("FAIL merge_reset_outputs: busy=%b cnt=%h hc=%h m=%h want all 0", busy, cnt_flat, hc_flat, m_flat);
    end
    @(negedge clk); reset = 1'b0;
    seen = 1'b0;
    for (int n = 0; n < 30; n++) begin
      @(posedge clk); #1;
      if (code_valid === 1'b1 || busy === 1'b1) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++; $display("FAIL merge_reset_no_code: got activity=%b want 0", seen);
    end
    run_block(q, 0);
    checks++;
    if (obs_cnt !== 48'h060504030201 || obs_hc !== 48'h010203010001 ||
        obs_m !== 48'h030303070f0f || obs_lat !== 10) begin
      errors++; $display("FAIL merge_reset_rerun: cnt=%h hc=%h m=%h lat=%0d", obs_cnt, obs_hc, obs_m, obs_lat);
    end
  endtask

  task automatic test_random;
    int q[$];
    int mask, len, r, s, first;
    for (int it = 0; it < 8; it++) begin
      q = {};
      mask = $urandom_range(1, 63);
      first = 1;
      for (int b = 0; b < 6; b++) if (mask[b]) begin first = b + 1; break; end
      len = $urandom_range(1, 40);
      for (int j = 0; j < len; j++) begin
        r = $urandom_range(0, 15);
        if (r >= 13) s = (r == 13) ? 0 : $urandom_range(7, 255);
        else begin
          s = $urandom_range(1, 6);
          if (!mask[s-1]) s = first;
        end
        q.push_back(s);
      end
      q.push_back(first);
      hist(q, NSYM);
      ref_model(NSYM, CODE_W);
      run_block(q, (it % 2 == 1) ? 2 : 0);
      checks++;
      if (obs_cnt !== exp_cnt_vec() || obs_cv !== 1'b1) begin
        errors++; $display("FAIL rand%0d_cnt: got %h cv=%b want %h", it, obs_cnt, obs_cv, exp_cnt_vec());
      end
      checks++;
      if (obs_hc !== exp_hc_vec() || obs_m !== exp_m_vec()) begin
        errors++; $display("FAIL rand%0d_code: got hc=%h m=%h want hc=%h m=%h", it, obs_hc, obs_m, exp_hc_vec(), exp_m_vec());
      end
      checks++;
      if (obs_lat !== mdl_lat || obs_err !== 1'b0 || obs_busy_ok !== 1'b1 || obs_busy_after !== 1'b0) begin
        errors++; $display("FAIL rand%0d_timing: lat=%0d want %0d err=%b busy_ok=%b busy_after=%b",
                           it, obs_lat, mdl_lat, obs_err, obs_busy_ok, obs_busy_after);
      end
    end
  endtask

  initial begin
    test_reset;
    test_spec_vector;
    test_single;
    test_invalid;
    test_counter_limit;
    test_code_err;
    test_reset_merge;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
